// File: rtl/snow64_alu_issue_stage.sv
// Buffered issue stage in front of the combinational snow64_alu: request FIFO plus registered result slot.
// Optional SNOW64_ALU_ISSUE_OPER_CHECK_EN flags reserved opcodes (OpDummy0-4) as illegal.
module snow64_alu_issue_stage #(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_a,
    input  logic [63:0]          in_b,
    input  logic [3:0]           in_oper,
    input  logic [1:0]           in_type_size,
    input  logic                 in_signedness,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic [63:0]          alu_a,
    output logic [63:0]          alu_b,
    output logic [3:0]           alu_oper,
    output logic [1:0]           alu_type_size,
    output logic                 alu_signedness,
    input  logic [63:0]          alu_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_illegal
);

    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

    logic [63:0]          a_mem    [FIFO_DEPTH];
    logic [63:0]          b_mem    [FIFO_DEPTH];
    logic [3:0]           oper_mem [FIFO_DEPTH];
    logic [1:0]           size_mem [FIFO_DEPTH];
    logic                 sign_mem [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem  [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          head_valid;
    logic          push;
    logic          pop;
    logic          head_illegal;
    logic [63:0]   load_data;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready   = !rst && (count < DEPTH_C);
    assign head_valid = (count != '0);
    assign push       = in_valid && in_ready;
    assign pop        = head_valid && (!out_valid || out_ready);

    always_comb begin
        alu_a          = '0;
        alu_b          = '0;
        alu_oper       = '0;
        alu_type_size  = '0;
        alu_signedness = 1'b0;
        if (head_valid) begin
            alu_a          = a_mem[rd_ptr];
            alu_b          = b_mem[rd_ptr];
            alu_oper       = oper_mem[rd_ptr];
            alu_type_size  = size_mem[rd_ptr];
            alu_signedness = sign_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr]    <= in_a;
            b_mem[wr_ptr]    <= in_b;
            oper_mem[wr_ptr] <= in_oper;
            size_mem[wr_ptr] <= in_type_size;
            sign_mem[wr_ptr] <= in_signedness;
            tag_mem[wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SNOW64_ALU_ISSUE_OPER_CHECK_EN
    assign head_illegal = alu_oper inside {4'd3, 4'd4, 4'd13, 4'd14, 4'd15};
    assign load_data    = head_illegal ? 64'd0 : alu_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_illegal <= 1'b0;
        end else if (pop) begin
            out_illegal <= head_illegal;
        end
    end
`else
    assign head_illegal = 1'b0;
    assign load_data    = alu_data;
    assign out_illegal  = head_illegal;
`endif

    // Result slot: load on pop, drop valid once consumed with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_tag   <= tag_mem[rd_ptr];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snow64_alu_issue_stage.sv
// Randomised scoreboard bench for snow64_alu_issue_stage with a stand-in ALU.
// Honours SNOW64_ALU_ISSUE_OPER_CHECK_EN the same way the design does.
module tb_snow64_alu_issue_stage;

    localparam int DEPTH = 2;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_a;
    logic [63:0]   in_b;
    logic [3:0]    in_oper;
    logic [1:0]    in_type_size;
    logic          in_signedness;
    logic [TW-1:0] in_tag;
    logic [63:0]   alu_a;
    logic [63:0]   alu_b;
    logic [3:0]    alu_oper;
    logic [1:0]    alu_type_size;
    logic          alu_signedness;
    logic [63:0]   alu_data;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [TW-1:0] out_tag;
    logic          out_illegal;

    snow64_alu_issue_stage #(.FIFO_DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_oper(in_oper),
        .in_type_size(in_type_size), .in_signedness(in_signedness),
        .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
        .alu_type_size(alu_type_size), .alu_signedness(alu_signedness),
        .alu_data(alu_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fake_alu(input logic [63:0] a, input logic [63:0] b,
                                             input logic [3:0] op, input logic [1:0] sz,
                                             input logic sg);
        return (a + b) ^ {op, sg, 57'd0, sz};
    endfunction

    // Stand-in for the combinational snow64_alu.
    assign alu_data = fake_alu(alu_a, alu_b, alu_oper, alu_type_size, alu_signedness);

    function automatic bit reserved_op(input logic [3:0] op);
        return (op == 4'd3) || (op == 4'd4) || (op >= 4'd13);
    endfunction

    typedef struct {
        logic [TW-1:0] tag;
        logic [63:0]   data;
        logic          ill;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          npop = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    int          pushed = 0;
    bit          hold_pend = 0;
    logic [63:0] hold_data;
    logic [TW-1:0] hold_tag;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op, input logic [1:0] sz, input logic sg,
                         input logic [TW-1:0] tg, input logic ordy);
        in_valid      = v;
        in_a          = a;
        in_b          = b;
        in_oper       = op;
        in_type_size  = sz;
        in_signedness = sg;
        in_tag        = tg;
        out_ready     = ordy;
    endtask

    // Called at posedge+1; samples mid-cycle, then advances to the next posedge+1.
    task automatic tick();
        exp_t e;
        #4;
        if (hold_pend) begin
            chk("hold_data", out_data, hold_data);
            chk("hold_tag", 64'(out_tag), 64'(hold_tag));
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        hold_tag  = out_tag;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_result", 64'(out_tag), 64'hFFFF);
            end else begin
                e = q.pop_front();
                chk("data", out_data, e.data);
                chk("tag", 64'(out_tag), 64'(e.tag));
                chk("illegal", 64'(out_illegal), 64'(e.ill));
            end
            if (npop == 0) first_pop = cyc;
            last_pop = cyc;
            npop++;
        end
        if (in_valid && in_ready) begin
`ifdef SNOW64_ALU_ISSUE_OPER_CHECK_EN
            e.ill = reserved_op(in_oper);
`else
            e.ill = 1'b0;
`endif
            e.tag  = in_tag;
            e.data = e.ill ? 64'd0
                           : fake_alu(in_a, in_b, in_oper, in_type_size, in_signedness);
            q.push_back(e);
            pushed++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", 64'(out_tag), 0);
        chk("rst_out_illegal", 64'(out_illegal), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_oper", 64'(alu_oper), 0);
        q.delete();
        hold_pend = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < budget && (q.size() != 0 || out_valid); i++) tick();
        chk("drain_empty", 64'(q.size()), 0);
    endtask

    task automatic fill3();
        drive(1, 64'h11, 64'h1, 4'd1, 2'd3, 1'b0, 4'd1, 0);
        tick();
        drive(1, 64'h22, 64'h2, 4'd6, 2'd2, 1'b1, 4'd2, 0);
        tick();
        drive(1, 64'h33, 64'h3, 4'd9, 2'd1, 1'b0, 4'd3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Single add: latency and ALU operand presentation.
        drive(1, 64'd5, 64'd3, 4'd0, 2'd3, 1'b0, 4'd1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lat_alu_a", alu_a, 64'd5);
        chk("lat_early_valid", 64'(out_valid), 0);
        tick();
        chk("lat_valid", 64'(out_valid), 1);
        chk("lat_tag", 64'(out_tag), 1);
        chk("lat_data", out_data, 64'd8 ^ {4'd0, 1'b0, 57'd0, 2'd3});
        drain(10);
        chk("idle_alu_a", alu_a, 0);

        // Backpressure: FIFO fills behind a held result.
        fill3();
        chk("bp_in_ready", 64'(in_ready), 0);
        chk("bp_out_valid", 64'(out_valid), 1);
        chk("bp_out_tag", 64'(out_tag), 1);
        tick();
        chk("bp_still_full", 64'(in_ready), 0);
        drain(10);

        // Reserved opcode 13.
        drive(1, 64'h40, 64'h2, 4'd13, 2'd0, 1'b1, 4'd7, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
`ifdef SNOW64_ALU_ISSUE_OPER_CHECK_EN
        chk("op13_data", out_data, 0);
        chk("op13_illegal", 64'(out_illegal), 1);
`else
        chk("op13_data", out_data, fake_alu(64'h40, 64'h2, 4'd13, 2'd0, 1'b1));
        chk("op13_illegal", 64'(out_illegal), 0);
`endif
        drain(10);

        // Throughput: 16 back-to-back requests.
        npop = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom),
                  2'($urandom), 1'($urandom), 4'(i), 1);
            tick();
        end
        drain(10);
        chk("tput_count", 64'(npop), 16);
        chk("tput_span", 64'(last_pop - first_pop), 15);

        // Reset while two entries are buffered and a result is held.
        fill3();
        chk("pre_rst_full", 64'(in_ready), 0);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stale_valid", 64'(out_valid), 0);
        end

        // Random valid/ready traffic.
        pushed = 0;
        for (int i = 0; i < 60000 && pushed < 10000; i++) begin
            drive($urandom_range(3, 0) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                  4'($urandom), 2'($urandom), 1'($urandom), 4'(pushed),
                  $urandom_range(3, 0) != 0);
            tick();
        end
        chk("rand_pushed", 64'(pushed), 10000);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snow64_alu_issue_stage.md
SNOW64_ALU_ISSUE_STAGE -- requirements
Module: snow64_alu_issue_stage

Parameters
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning input request buffer entries (legal values 2 or 4).
REQ-002 SHALL have parameter TAG_WIDTH, default 4, meaning width of the caller-supplied request tag carried to the output.

Interface
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  request accepted when in_valid && in_ready at a clock edge.
REQ-007 in_a, in_b  in  64 each  operands.
REQ-008 in_oper  in  4  ALU operation (AluOper encoding).
REQ-009 in_type_size  in  2  element size: 0=8, 1=16, 2=32, 3=64 bits.
REQ-010 in_signedness  in  1  signed-operation flag.
REQ-011 in_tag  in  TAG_WIDTH  request tag.
REQ-012 alu_a, alu_b  out  64 each  operands to the combinational snow64_alu.
REQ-013 alu_oper, alu_type_size, alu_signedness  out  4/2/1  control to snow64_alu.
REQ-014 alu_data  in  64  combinational result from snow64_alu.
REQ-015 out_valid  out  1  result present.
REQ-016 out_ready  in  1  consumer takes result when out_valid && out_ready.
REQ-017 out_data  out  64  registered result; out_tag  out  TAG_WIDTH  tag of that result.
REQ-018 out_illegal  out  1  result came from a reserved opcode (see Configuration).

Function
REQ-019 Accepted requests SHALL enter a FIFO of FIFO_DEPTH entries; order preserved end to end.
REQ-020 in_ready SHALL equal (FIFO count < FIFO_DEPTH), computed from registered count only (no combinational path from out_ready).
REQ-021 FIFO head fields SHALL drive alu_* outputs directly; with FIFO empty alu_* SHALL be all-zero.
REQ-022 Output register SHALL load {alu_data, head tag} and pop the head when head valid && (!out_valid || out_ready).
REQ-023 Minimum latency: request accepted at edge N SHALL appear with out_valid=1 after edge N+1 (one FIFO cycle, one output cycle).
REQ-024 Throughput SHALL be one result per cycle while out_ready=1 and in_valid=1.
REQ-025 out_valid SHALL clear on consume when no head is available; out_data/out_tag SHALL hold while out_valid && !out_ready.
REQ-026 Simultaneous push and pop in one cycle SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 Push into an empty FIFO with output slot free SHALL not bypass the FIFO (latency fixed per REQ-023).
REQ-028 Count SHALL never exceed FIFO_DEPTH nor underflow; push when full is impossible by REQ-020.

Reset
REQ-029 While rst=1: FIFO count, pointers=0; in_ready=0 during reset, 1 first cycle after release; out_valid=0, out_data=0, out_tag=0, out_illegal=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered and output-held requests without producing a result.

Configuration
REQ-031 Macro SNOW64_ALU_ISSUE_OPER_CHECK_EN: when defined, opcodes 3, 4, 13, 14, 15 (OpDummy0-4) SHALL load out_data=0 and out_illegal=1; legal opcodes load out_illegal=0.
REQ-032 When SNOW64_ALU_ISSUE_OPER_CHECK_EN is undefined, out_data SHALL always equal alu_data and out_illegal SHALL be tied 0.

Verification
REQ-033 Reset, then one request a=5, b=3, oper=OpAdd, size=3, tag=1, out_ready=1 -> out_valid one cycle after acceptance+1, alu_a=5 seen, out_tag=1.
REQ-034 out_ready=0, push tags 1,2,3 back-to-back (depth 2) -> in_ready drops after tags 2,3 fill FIFO (tag 1 in output reg); release out_ready -> tags 1,2,3 emerge in order.
REQ-035 Continuous in_valid and out_ready=1 for 16 requests -> 16 results on 16 consecutive cycles, tags 0-15 in order.
REQ-036 oper=13 with macro defined -> out_data=0, out_illegal=1; same without macro -> out_data=alu_data, out_illegal=0.
REQ-037 rst asserted with 2 FIFO entries and out_valid=1 -> immediately out_valid=0, in_ready=0; after release no stale result appears.
REQ-038 Random valid/ready toggling, 10,000 requests -> scoreboard matches every tag and data, no loss or duplication.
